// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder.
//   CLA_GRP_W : width of one look-ahead group (4 bits)
//   cla_grp_t : one group's operand/sum slice
//   cla_pg_t  : group propagate/generate pair
//   grp_pg()  : group-level propagate/generate from two 4-bit operands
package cla_pkg;

    localparam int CLA_GRP_W = 4;

    typedef logic [CLA_GRP_W-1:0] cla_grp_t;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

    function automatic cla_pg_t grp_pg(input cla_grp_t a, input cla_grp_t b);
        cla_grp_t pb;
        cla_grp_t gb;
        cla_pg_t  r;
        pb  = a ^ b;
        gb  = a & b;
        r.p = &pb;
        r.g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One 4-bit carry-look-ahead group.
//   x, y  in  4  operand bits (y already inverted for subtraction)
//   c_in  in  1  carry into bit 0 of the group
//   sum   out 4  group sum
//   p, g  out 1  group propagate / generate for the next look-ahead level
module cla_group
    import cla_pkg::*;
(
    input  cla_grp_t x,
    input  cla_grp_t y,
    input  logic     c_in,
    output cla_grp_t sum,
    output logic     p,
    output logic     g
);

    cla_grp_t   pb;
    logic [2:0] gb;
    cla_grp_t   c;
    cla_pg_t    pg;

    always_comb begin
        pb   = x ^ y;
        gb   = x[2:0] & y[2:0];
        // Bit carries fully expanded so each depends only on pb/gb and c_in.
        c[0] = c_in;
        c[1] = gb[0] | (pb[0] & c_in);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c_in);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & c_in);
        sum  = pb ^ c;
        pg   = grp_pg(x, y);
        p    = pg.p;
        g    = pg.g;
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined WIDTH-bit carry-look-ahead adder/subtractor with valid/ready.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; level 0
// registers the (inverted) operands, level k holds the result of slice k-1,
// and a final output register presents z/cout. Latency STAGES+1 edges.
// Optional feature: define CLA_OVF_EN to add the registered signed-overflow
// output ovf.
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake (in_ready = global advance)
//   x, y, cin, sub   operands; sub=1 computes x-y-cin
//   out_valid/ready  result handshake
//   z, cout          result and carry-out (sub: 1 = no borrow)
//   ovf              signed overflow (CLA_OVF_EN only)
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG  = WIDTH / CLA_GRP_W;
    localparam int GPS = NG / STAGES;
    localparam int SW  = WIDTH / STAGES;

    if ((WIDTH % CLA_GRP_W) != 0 || ((WIDTH / CLA_GRP_W) % STAGES) != 0) begin : g_bad_cfg
        $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of 4 and WIDTH/4 divisible by STAGES");
    end

    logic                         adv;
    logic [STAGES:0]              vld_pipe_q, vld_pipe_d;
    // Per level: slices already finished hold the sum in a and zero in b,
    // slices still pending hold the operands, so a^b at the last level is z.
    logic [STAGES:0][WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [STAGES:0]              c_q, c_d;
    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             z_q, z_d;
    logic                         cout_q, cout_d;

    logic [WIDTH-1:0]             gsum;
    logic [NG-1:0]                gp, gg, gc;
    logic [STAGES-1:0]            sc;
    logic                         c_run;

    // Single stall point: the whole pipe advances only if the output can move.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        for (genvar g = 0; g < GPS; g++) begin : g_grp
            localparam int IDX = s * GPS + g;
            cla_group u_grp (
                .x    (a_q[s][IDX*CLA_GRP_W +: CLA_GRP_W]),
                .y    (b_q[s][IDX*CLA_GRP_W +: CLA_GRP_W]),
                .c_in (gc[IDX]),
                .sum  (gsum[IDX*CLA_GRP_W +: CLA_GRP_W]),
                .p    (gp[IDX]),
                .g    (gg[IDX])
            );
        end
    end

    // Group-level look-ahead inside each slice, seeded by the carry
    // registered at the slice's input level.
    always_comb begin
        gc    = '0;
        sc    = '0;
        c_run = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            c_run = c_q[s];
            for (int g = 0; g < GPS; g++) begin
                gc[s*GPS+g] = c_run;
                c_run       = gg[s*GPS+g] | (gp[s*GPS+g] & c_run);
            end
            sc[s] = c_run;
        end
    end

    always_comb begin
        vld_pipe_d  = vld_pipe_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        cout_d      = cout_q;
        if (adv) begin
            vld_pipe_d[0] = in_valid;
            a_d[0]        = x;
            b_d[0]        = y ^ {WIDTH{sub}};
            c_d[0]        = cin ^ sub;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe_d[k]              = vld_pipe_q[k-1];
                a_d[k]                     = a_q[k-1];
                b_d[k]                     = b_q[k-1];
                a_d[k][(k-1)*SW +: SW]     = gsum[(k-1)*SW +: SW];
                b_d[k][(k-1)*SW +: SW]     = '0;
                c_d[k]                     = sc[k-1];
            end
            out_valid_d = vld_pipe_q[STAGES];
            // Result registers only load real beats so bubbles leave z intact.
            if (vld_pipe_q[STAGES]) begin
                z_d    = a_q[STAGES] ^ b_q[STAGES];
                cout_d = c_q[STAGES];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            cout_q      <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign cout      = cout_q;

`ifdef CLA_OVF_EN
    logic ovf_lvl_q, ovf_lvl_d;
    logic ovf_q, ovf_d;
    logic msb_c;

    // Carry into the MSB recovered from the MSB sum bit and its operands.
    always_comb begin
        ovf_lvl_d = ovf_lvl_q;
        ovf_d     = ovf_q;
        msb_c     = gsum[WIDTH-1] ^ a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1];
        if (adv) begin
            ovf_lvl_d = msb_c ^ sc[STAGES-1];
            if (vld_pipe_q[STAGES]) begin
                ovf_d = ovf_lvl_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_lvl_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_lvl_q <= ovf_lvl_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe (WIDTH=16, STAGES=2).
module tb_cla_adder_pipe;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] x, y, z;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] z;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cla_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
`ifdef CLA_OVF_EN
        .ovf       (ovf),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [W:0]  full;
        int          sa, sb2, r;
        sa  = $signed(a);
        sb2 = $signed(b);
        if (!sb) begin
            full   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            e.z    = full[W-1:0];
            e.cout = full[W];
            r      = sa + sb2 + int'(ci);
        end else begin
            e.z    = a - b - W'(ci);
            e.cout = ({1'b0, a} >= ({1'b0, b} + (W+1)'(ci)));
            r      = sa - sb2 - int'(ci);
        end
        e.ovf = (r > 32767) || (r < -32768);
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat z=%0h cout=%0b", z, cout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("z", 32'(z), 32'(e.z));
                chk("cout", 32'(cout), 32'(e.cout));
`ifdef CLA_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Present one beat for one cycle; called #1 after a rising edge.
    task automatic send_try(input logic [W-1:0] xi, input logic [W-1:0] yi,
                            input logic ci, input logic si, output bit acc);
        x = xi; y = yi; cin = ci; sub = si; in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready && !rst;
        if (acc) exp_q.push_back(model(xi, yi, ci, si));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xi, input logic [W-1:0] yi,
                        input logic ci, input logic si);
        bit acc;
        int n;
        n = 0;
        do begin
            send_try(xi, yi, ci, si, acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b expected=1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
        end
        repeat (2) step();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit acc;
        int n, nacc;
        logic [W-1:0] zs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency from an empty pipe
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle();
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(S + 1));
        wait_drain();

        // Directed arithmetic
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        idle();
        wait_drain();

        // Back-to-back: 4 results on consecutive cycles
        for (int i = 0; i < 4; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        chk("b2b_gap", 32'(out_valid), 32'd0);
        wait_drain();

        // Stall with a full pipe
        out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            send_try(pick(), pick(), 1'($urandom), 1'($urandom), acc);
            if (acc) nacc++;
        end
        idle();
        chk("stall_accepted", 32'(nacc), 32'(S + 2));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        zs = z;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_z_stable", 32'(z), 32'(zs));
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        // Release and push a new beat in the same cycle the output pops
        out_ready = 1'b1;
        send_try(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, acc);
        chk("pop_push_accept", 32'(acc), 32'd1);
        idle();
        wait_drain();

        // Reset with two beats in flight; a beat shown during reset is dropped
        send(pick(), pick(), 1'b0, 1'b0);
        send(pick(), pick(), 1'b1, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        x = 16'h1111; y = 16'h2222; in_valid = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        idle();
        repeat (8) step();
        chk("midrst_leftover", 32'(exp_q.size()), 32'd0);

`ifdef CLA_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        idle();
        wait_drain();
`endif

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) send_try(pick(), pick(), 1'($urandom), 1'($urandom), acc);
            else begin
                idle();
                step();
            end
        end
        idle();
        out_ready = 1'b1;
        wait_drain();
        chk("final_leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
